// File: rtl/video_pkg.sv
// Shared types for the video mode controller.
//   state_e         : mode-switch sequencer states
//   mode_t          : one complete set of mixer mode selections
//   MODE_RESET      : modes applied out of reset (scandoubler bypassed)
//   is_major_change : true when a request would disturb sync timing
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_MUTE    = 2'd2,
    ST_SETTLE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] scanlines;
    logic       sd_disable;
    logic       ypbpr;
    logic       ypbpr_full;
  } mode_t;

  localparam mode_t MODE_RESET = '{scanlines: 2'd0, sd_disable: 1'b1,
                                   ypbpr: 1'b0, ypbpr_full: 1'b0};

  // Toggling the scandoubler or the YPbPr sync format changes sync timing,
  // so the output must be muted around such a switch.
  function automatic logic is_major_change(input mode_t req, input mode_t cur);
    return (req.sd_disable != cur.sd_disable) || (req.ypbpr != cur.ypbpr);
  endfunction

endpackage

// File: rtl/sync_meter.sv
// Source sync timing measurement.
//   clk_sys, reset  : clock, asynchronous active-high reset
//   ce_pix          : pixel clock enable
//   hsync, vsync    : source sync, positive pulses
//   vs_rise         : one-cycle VSync rising-edge strobe (shared with the FSM)
//   line_length     : ce_pix count of the last complete line
//   frame_lines     : line count of the last complete frame
//   timing_valid    : last two frames measured identically
module sync_meter (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hsync,
  input  logic        vsync,
  output logic        vs_rise,
  output logic [11:0] line_length,
  output logic [9:0]  frame_lines,
  output logic        timing_valid
);

  logic        hs_prev_q, vs_prev_q;
  logic        hs_rise;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [11:0] line_length_q, line_length_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic [11:0] ll_at_vs_q, ll_at_vs_d;
  logic        timing_valid_q, timing_valid_d;

  always_comb begin
    hs_rise = hsync & ~hs_prev_q;
    vs_rise = vsync & ~vs_prev_q;

    pix_cnt_d = pix_cnt_q;
    if (hs_rise)
      pix_cnt_d = '0;
    else if (ce_pix && (pix_cnt_q != '1))
      pix_cnt_d = pix_cnt_q + 1'b1;
    line_length_d = hs_rise ? pix_cnt_q : line_length_q;

    line_cnt_d = line_cnt_q;
    if (vs_rise)
      line_cnt_d = '0;
    else if (hs_rise && (line_cnt_q != '1))
      line_cnt_d = line_cnt_q + 1'b1;
    frame_lines_d = vs_rise ? line_cnt_q : frame_lines_q;

    // line_length_d already reflects an HSync edge coinciding with VSync,
    // so the comparison uses the value being published this cycle.
    ll_at_vs_d     = vs_rise ? line_length_d : ll_at_vs_q;
    timing_valid_d = timing_valid_q;
    if (vs_rise)
      timing_valid_d = (line_length_d == ll_at_vs_q) && (line_cnt_q == frame_lines_q);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_prev_q      <= 1'b0;
      vs_prev_q      <= 1'b0;
      pix_cnt_q      <= '0;
      line_cnt_q     <= '0;
      line_length_q  <= '0;
      frame_lines_q  <= '0;
      ll_at_vs_q     <= '0;
      timing_valid_q <= 1'b0;
    end else begin
      hs_prev_q      <= hsync;
      vs_prev_q      <= vsync;
      pix_cnt_q      <= pix_cnt_d;
      line_cnt_q     <= line_cnt_d;
      line_length_q  <= line_length_d;
      frame_lines_q  <= frame_lines_d;
      ll_at_vs_q     <= ll_at_vs_d;
      timing_valid_q <= timing_valid_d;
    end
  end

  assign line_length  = line_length_q;
  assign frame_lines  = frame_lines_q;
  assign timing_valid = timing_valid_q;

endmodule

// File: rtl/video_mode_ctrl.sv
// Glitch-free video mode switching for a 15 kHz source feeding a mixer.
// Requested modes are applied on a VSync boundary; sync-affecting switches
// blank the output for one frame before and SETTLE_FRAMES frames after the
// switch. A watchdog applies requests directly if VSync stops.
//   clk_sys, reset             : clock, asynchronous active-high reset
//   ce_pix, HSync, VSync       : source pixel enable and sync
//   req_*                      : requested modes
//   scanlines .. ypbpr_full    : applied modes (registered)
//   blank                      : force black on mixer output
//   busy                       : a switch sequence is in progress
//   line_length, frame_lines,
//   timing_valid               : source timing measurement
module video_mode_ctrl
  import video_pkg::*;
#(
  parameter int SETTLE_FRAMES = 2,
  parameter int VS_TIMEOUT_W  = 22
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        HSync,
  input  logic        VSync,
  input  logic [1:0]  req_scanlines,
  input  logic        req_sd_disable,
  input  logic        req_ypbpr,
  input  logic        req_ypbpr_full,
  output logic [1:0]  scanlines,
  output logic        scandoubler_disable,
  output logic        ypbpr,
  output logic        ypbpr_full,
  output logic        blank,
  output logic        busy,
  output logic [11:0] line_length,
  output logic [9:0]  frame_lines,
  output logic        timing_valid
);

  localparam int SETTLE_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES);
  // The watchdog fires on the cycle its count would reach all-ones.
  localparam logic [VS_TIMEOUT_W-1:0] WD_FIRE_AT = {{(VS_TIMEOUT_W-1){1'b1}}, 1'b0};

  logic                    vs_rise;
  mode_t                   req;
  logic                    changed, major, wd_fire;
  state_e                  state_q, state_d;
  mode_t                   applied_q, applied_d;
  logic                    blank_q, blank_d;
  logic [SETTLE_W-1:0]     settle_q, settle_d, settle_inc;
  logic [VS_TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;

  sync_meter u_meter (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce_pix       (ce_pix),
    .hsync        (HSync),
    .vsync        (VSync),
    .vs_rise      (vs_rise),
    .line_length  (line_length),
    .frame_lines  (frame_lines),
    .timing_valid (timing_valid)
  );

  assign req        = {req_scanlines, req_sd_disable, req_ypbpr, req_ypbpr_full};
  assign changed    = (req != applied_q);
  assign major      = is_major_change(req, applied_q);
  assign wd_fire    = !vs_rise && (wd_cnt_q == WD_FIRE_AT);
  assign settle_inc = settle_q + 1'b1;

  // State and applied-mode register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      applied_q <= MODE_RESET;
      blank_q   <= 1'b0;
      settle_q  <= '0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      applied_q <= applied_d;
      blank_q   <= blank_d;
      settle_q  <= settle_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    applied_d = applied_q;
    blank_d   = blank_q;
    settle_d  = settle_q;
    wd_cnt_d  = '0;
    case (state_q)
      ST_IDLE: begin
        // A VSync edge in this same cycle is not used; the switch waits
        // for the next one so the request has a full frame to settle.
        if (changed)
          state_d = ST_PENDING;
      end
      ST_PENDING: begin
        wd_cnt_d = vs_rise ? '0 : wd_cnt_q + 1'b1;
        if (!changed) begin
          state_d = ST_IDLE;
        end else if (vs_rise) begin
          if (major) begin
            blank_d = 1'b1;
            state_d = ST_MUTE;
          end else begin
            applied_d = req;
            state_d   = ST_IDLE;
          end
        end else if (wd_fire) begin
          applied_d = req;
          wd_cnt_d  = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_MUTE: begin
        wd_cnt_d = vs_rise ? '0 : wd_cnt_q + 1'b1;
        if (vs_rise) begin
          applied_d = req;
          settle_d  = '0;
          state_d   = ST_SETTLE;
        end else if (wd_fire) begin
          applied_d = req;
          blank_d   = 1'b0;
          wd_cnt_d  = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (vs_rise) begin
          settle_d = settle_inc;
          if (settle_inc >= SETTLE_LAST) begin
            blank_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    scanlines           = applied_q.scanlines;
    scandoubler_disable = applied_q.sd_disable;
    ypbpr               = applied_q.ypbpr;
    ypbpr_full          = applied_q.ypbpr_full;
    blank               = blank_q;
    busy                = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Scoreboard bench for video_mode_ctrl: a frame/phase-level model predicts
// every output change together with the cycle it must appear in; a monitor
// compares each observed change against the queued prediction.
module tb_video_mode_ctrl;

  localparam int SF     = 2;
  localparam int WDW    = 8;
  localparam int WD_MAX = (1 << WDW) - 1;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0, HSync = 1'b0, VSync = 1'b0;
  logic [1:0]  req_scanlines = 2'd0;
  logic        req_sd_disable = 1'b1, req_ypbpr = 1'b0, req_ypbpr_full = 1'b0;
  logic [1:0]  scanlines;
  logic        scandoubler_disable, ypbpr, ypbpr_full, blank, busy;
  logic [11:0] line_length;
  logic [9:0]  frame_lines;
  logic        timing_valid;

  always #5 clk_sys = ~clk_sys;

  video_mode_ctrl #(.SETTLE_FRAMES(SF), .VS_TIMEOUT_W(WDW)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .HSync(HSync), .VSync(VSync),
    .req_scanlines(req_scanlines), .req_sd_disable(req_sd_disable),
    .req_ypbpr(req_ypbpr), .req_ypbpr_full(req_ypbpr_full),
    .scanlines(scanlines), .scandoubler_disable(scandoubler_disable),
    .ypbpr(ypbpr), .ypbpr_full(ypbpr_full), .blank(blank), .busy(busy),
    .line_length(line_length), .frame_lines(frame_lines), .timing_valid(timing_valid)
  );

  int tests = 0, fails = 0, cyc = 0, rst_hold = 0;

  typedef struct { int c; logic [29:0] v; } exp_t;
  exp_t sb_q[$];

  wire logic [29:0] dut_v = {scanlines, scandoubler_disable, ypbpr, ypbpr_full, blank, busy,
                             line_length, frame_lines, timing_valid};

  // ---------------- reference model ----------------
  int         m_pix, m_ll, m_lines, m_fl, m_ll_vs, m_rises, m_wd;
  bit         m_tv, m_hs_prev, m_vs_prev, m_busy, m_blank;
  logic [1:0] a_sl;
  bit         a_sd, a_yp, a_ypf;
  logic [29:0] m_last;

  function automatic void model_reset();
    m_pix = 0; m_ll = 0; m_lines = 0; m_fl = 0; m_ll_vs = 0; m_tv = 0;
    m_hs_prev = 0; m_vs_prev = 0; m_busy = 0; m_blank = 0; m_rises = 0; m_wd = 0;
    a_sl = 2'd0; a_sd = 1; a_yp = 0; a_ypf = 0;
  endfunction

  function automatic logic [29:0] model_vec();
    return {a_sl, a_sd, a_yp, a_ypf, m_blank, m_busy, 12'(m_ll), 10'(m_fl), m_tv};
  endfunction

  function automatic bit req_differs();
    return (req_scanlines != a_sl) || (req_sd_disable != a_sd) ||
           (req_ypbpr != a_yp) || (req_ypbpr_full != a_ypf);
  endfunction

  function automatic void apply_req();
    a_sl = req_scanlines; a_sd = req_sd_disable; a_yp = req_ypbpr; a_ypf = req_ypbpr_full;
  endfunction

  // One clk_sys edge, using the inputs present just before the edge.
  function automatic void model_step();
    bit hs_r, vs_r;
    int ll_new;
    if (reset) begin model_reset(); return; end
    hs_r = HSync && !m_hs_prev;
    vs_r = VSync && !m_vs_prev;
    m_hs_prev = HSync; m_vs_prev = VSync;
    // measurement
    ll_new = hs_r ? m_pix : m_ll;
    if (vs_r) begin
      m_tv = (ll_new == m_ll_vs) && (m_lines == m_fl);
      m_ll_vs = ll_new; m_fl = m_lines; m_lines = 0;
    end else if (hs_r && m_lines < 1023) m_lines++;
    if (hs_r) begin m_ll = m_pix; m_pix = 0; end
    else if (ce_pix && m_pix < 4095) m_pix++;
    // mode sequencing: m_rises counts VSync rises since the output was blanked
    if (!m_busy) begin
      if (req_differs()) begin m_busy = 1; m_wd = 0; end
    end else if (!m_blank) begin
      if (!req_differs()) m_busy = 0;
      else if (vs_r) begin
        if ((req_sd_disable != a_sd) || (req_ypbpr != a_yp)) begin
          m_blank = 1; m_rises = 0; m_wd = 0;
        end else begin apply_req(); m_busy = 0; end
      end else begin
        m_wd++;
        if (m_wd == WD_MAX) begin apply_req(); m_busy = 0; end
      end
    end else begin
      if (vs_r) begin
        m_rises++; m_wd = 0;
        if (m_rises == 1) apply_req();
        if (m_rises >= 1 + SF) begin m_blank = 0; m_busy = 0; end
      end else if (m_rises == 0) begin
        m_wd++;
        if (m_wd == WD_MAX) begin apply_req(); m_blank = 0; m_busy = 0; end
      end
    end
  endfunction

  // ---------------- source sync generator ----------------
  int ppl = 8, nl = 6, ppl_nx = 8, nl_nx = 6, lc = 0, ln = 0;
  bit vs_en = 1;

  function automatic void gen_set();
    ce_pix = (lc % 4 == 0);
    HSync  = (lc == 1) || (lc == 2);
    VSync  = vs_en && (ln == 0) && (lc >= 2) && (lc < 6);
  endfunction

  function automatic void gen_next();
    lc++;
    if (lc == 4 * ppl) begin
      lc = 0; ln++;
      if (ln >= nl) begin ln = 0; ppl = ppl_nx; nl = nl_nx; end
    end
    gen_set();
  endfunction

  task automatic tick(input int n);
    logic [29:0] v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      cyc++;
      model_step();
      #1;
      if (rst_hold > 0) begin reset = 1; rst_hold--; model_reset(); end
      else reset = 0;
      gen_next();
      v = model_vec();
      if (v != m_last) begin sb_q.push_back('{cyc, v}); m_last = v; end
    end
  endtask

  task automatic chk(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic [29:0] mon_last;
  bit mon_on = 0, saw_blank = 0, saw_busy = 0;

  always @(negedge clk_sys) begin
    exp_t e;
    if (mon_on) begin
      if (blank) saw_blank = 1;
      if (busy) saw_busy = 1;
      if (dut_v !== mon_last) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, dut_v);
        end else begin
          e = sb_q.pop_front();
          if ((e.v !== dut_v) || (e.c != cyc)) begin
            fails++;
            $display("FAIL outputs cyc=%0d got=%h required=%h at cyc %0d", cyc, dut_v, e.v, e.c);
          end
        end
        mon_last = dut_v;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    model_reset();
    m_last = model_vec();
    gen_set();
    rst_hold = 3;
    tick(4);
    chk("rst_scanlines", scanlines, 0);
    chk("rst_sd_disable", scandoubler_disable, 1);
    chk("rst_ypbpr", ypbpr, 0);
    chk("rst_ypbpr_full", ypbpr_full, 0);
    chk("rst_blank", blank, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_length", line_length, 0);
    chk("rst_frame_lines", frame_lines, 0);
    chk("rst_timing_valid", timing_valid, 0);
    mon_last = m_last;
    mon_on = 1;

    // steady source, 8 px x 6 lines
    tick(4 * 192);
    chk("steady_line_length", line_length, 8);
    chk("steady_frame_lines", frame_lines, 6);
    chk("steady_timing_valid", timing_valid, 1);

    // minor change mid-frame
    tick(50);
    saw_blank = 0; saw_busy = 0;
    req_scanlines = 2'd2;
    tick(2 * 192);
    chk("minor_busy_seen", saw_busy, 1);
    chk("minor_no_blank", saw_blank, 0);
    chk("minor_scanlines", scanlines, 2);

    // major change
    req_sd_disable = 1'b0;
    tick(6 * 192);
    chk("major_sd_disable", scandoubler_disable, 0);
    chk("major_blank_end", blank, 0);

    // request reverted before any VSync
    for (int k = 0; k < 400 && ln == 0; k++) tick(1);
    saw_blank = 0;
    req_ypbpr = 1'b1;
    tick(3);
    req_ypbpr = 1'b0;
    tick(200);
    chk("revert_ypbpr", ypbpr, 0);
    chk("revert_busy", busy, 0);
    chk("revert_no_blank", saw_blank, 0);

    // watchdog with VSync stopped
    vs_en = 0;
    req_ypbpr = 1'b1;
    tick(255);
    chk("wd_before_ypbpr", ypbpr, 0);
    chk("wd_before_busy", busy, 1);
    tick(1);
    chk("wd_ypbpr", ypbpr, 1);
    chk("wd_busy", busy, 0);
    vs_en = 1;
    tick(400);

    // reset during SETTLE
    req_sd_disable = 1'b1;
    guard = 0;
    while (!(m_busy && m_blank && m_rises >= 1) && guard < 2000) begin tick(1); guard++; end
    chk("settle_reached", int'(guard < 2000), 1);
    rst_hold = 1;
    tick(1);
    #2;
    chk("rst_settle_blank", blank, 0);
    chk("rst_settle_sd", scandoubler_disable, 1);
    chk("rst_settle_tv", timing_valid, 0);
    chk("rst_settle_busy", busy, 0);
    tick(600);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin ppl_nx = $urandom_range(4, 10); nl_nx = $urandom_range(3, 6); end
      req_scanlines = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) req_sd_disable = 1'($urandom);
      if ($urandom_range(0, 2) == 0) req_ypbpr = 1'($urandom);
      req_ypbpr_full = 1'($urandom);
      vs_en = (r != 9);
      if (it % 13 == 12) rst_hold = $urandom_range(1, 2);
      tick($urandom_range(1, 400));
    end
    vs_en = 1;
    tick(1500);
    @(negedge clk_sys);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_mode_ctrl.md
VIDEO_MODE_CTRL -- requirements
Module: video_mode_ctrl

Interface
REQ-001 Parameter SETTLE_FRAMES, default 2: number of frames output stays blanked after a sync-affecting mode switch.
REQ-002 Parameter VS_TIMEOUT_W, default 22: width of the missing-VSync watchdog counter.
REQ-003 clk_sys  in  1  master clock; one clock domain only.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 ce_pix  in  1  pixel clock enable.
REQ-006 HSync, VSync  in  1 each  source (15 kHz) sync, positive pulses, synchronous to clk_sys.
REQ-007 req_scanlines  in  2  requested scanline mode; req_sd_disable, req_ypbpr, req_ypbpr_full  in  1 each  requested modes.
REQ-008 scanlines  out  2; scandoubler_disable, ypbpr, ypbpr_full  out  1 each  applied modes, driving the mixer.
REQ-009 blank  out  1  force black on mixer output.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 line_length  out  12  measured ce_pix count per line.
REQ-012 frame_lines  out  10  measured lines per frame.
REQ-013 timing_valid  out  1  two consecutive identical frame measurements.

Function
REQ-014 Edges SHALL be detected from a registered copy of the previous sample: rise = prev 0 and current 1, one clk_sys cycle.
REQ-015 Pixel counter SHALL increment on ce_pix, saturating at 4095, and clear on HSync rise; on that rise line_length SHALL load the count.
REQ-016 Line counter SHALL increment on HSync rise, saturating at 1023, and clear on VSync rise; on that rise frame_lines SHALL load the count.
REQ-017 timing_valid SHALL update on each VSync rise: 1 if the new line_length and frame_lines equal the values captured at the previous VSync rise, else 0.
REQ-018 Major change = req_sd_disable or req_ypbpr differs from the applied value; minor change = only req_scanlines or req_ypbpr_full differ.
REQ-019 States: IDLE, PENDING, MUTE, SETTLE.
REQ-020 IDLE -> PENDING on the cycle any request differs from the applied value.
REQ-021 In PENDING, on VSync rise with a minor change: all four modes SHALL be applied in that cycle, -> IDLE, and blank SHALL stay 0.
REQ-022 In PENDING, on VSync rise with a major change: blank=1, -> MUTE, modes not yet applied.
REQ-023 In MUTE, on the next VSync rise: all four request values SHALL be applied, frame counter cleared, -> SETTLE.
REQ-024 In SETTLE: count VSync rises; on reaching SETTLE_FRAMES: blank=0, -> IDLE.
REQ-025 Requests changing during MUTE or SETTLE SHALL NOT abort the sequence; they are re-evaluated in IDLE.
REQ-026 Requests reverting to the applied values while in PENDING SHALL return the FSM to IDLE without applying anything.
REQ-027 Watchdog: in PENDING or MUTE, clk_sys cycles without a VSync rise SHALL be counted; on all-ones: apply all requests immediately, blank=0, -> IDLE.
REQ-028 If VSync rises and the request changes in the same cycle in IDLE, the FSM SHALL enter PENDING and wait for the following VSync rise.
REQ-029 Applied-mode outputs SHALL be registered, changing only at the transitions defined in REQ-021, REQ-023 and REQ-027.

Reset
REQ-030 On reset: state IDLE; scanlines 0; scandoubler_disable 1; ypbpr 0; ypbpr_full 0; blank 0; busy 0.
REQ-031 On reset: line_length 0, frame_lines 0, timing_valid 0, all counters 0, edge registers 0.
REQ-032 Reset asserted mid-sequence SHALL abort it, with the reset values visible in the cycle after assertion.

Structure
REQ-033 Shared package video_pkg SHALL hold the FSM state enum, a mode struct (scanlines, sd_disable, ypbpr, ypbpr_full) and its reset constant.
REQ-034 Timing measurement (REQ-015 to REQ-017) SHALL be a sub-module sync_meter; the FSM and watchdog stay in video_mode_ctrl.

Verification
REQ-035 Steady source (ce_pix 1 of 4 cycles, 768 px per line, 312 lines per frame) for 3 frames -> line_length 768, frame_lines 312, timing_valid 1 after the second VSync rise.
REQ-036 req_scanlines 0->2 mid-frame -> busy 1, scanlines 2 on the cycle after the next VSync rise, blank never 1.
REQ-037 req_sd_disable 1->0 -> blank 1 at VSync rise #1, scandoubler_disable 0 at rise #2, blank 0 at rise #4 (SETTLE_FRAMES=2).
REQ-038 VSync held low, req_ypbpr 0->1, VS_TIMEOUT_W=8 -> ypbpr 1 and busy 0 after 255 cycles.
REQ-039 req_ypbpr 0->1 then back to 0 before VSync -> FSM returns to IDLE, ypbpr stays 0, blank stays 0.
REQ-040 Reset asserted during SETTLE -> blank 0, scandoubler_disable 1, timing_valid 0 the next cycle.
